// File: rtl/exec_mul_pkg.sv
// Shared types and constants for the execute-stage multiply sequencer.
//   mul_state_t   : controller FSM state (IDLE / RUN / DONE)
//   MUL_DEFAULT_N : default operand width
package exec_mul_pkg;

  localparam int MUL_DEFAULT_N = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/exec_mul_ctrl_if.sv
// Request/result bundle between the EX stage and the multiply sequencer.
//   master : EX side; drives start_E, hi_sel_E, opA_E, opB_E, flush_E and
//            result_ready; observes stall_E, busy, result_valid and result.
//   slave  : the sequencer (exec_mul_ctrl).
// Handshake: result_valid/result are held stable until result_ready is seen
// high while result_valid is high; that cycle is the transfer and the
// sequencer returns to IDLE on the following edge. result_valid never waits
// on result_ready to rise.
interface exec_mul_ctrl_if
  import exec_mul_pkg::*;
#(
  parameter int N = MUL_DEFAULT_N
);

  logic         start_E;
  logic         hi_sel_E;
  logic [N-1:0] opA_E;
  logic [N-1:0] opB_E;
  logic         flush_E;
  logic         result_ready;
  logic         stall_E;
  logic         busy;
  logic         result_valid;
  logic [N-1:0] result;

  modport master (
    output start_E, hi_sel_E, opA_E, opB_E, flush_E, result_ready,
    input  stall_E, busy, result_valid, result
  );

  modport slave (
    input  start_E, hi_sel_E, opA_E, opB_E, flush_E, result_ready,
    output stall_E, busy, result_valid, result
  );

endinterface

// File: rtl/mul_step.sv
// One radix-2 shift-add iteration of the unsigned multiply loop.
//   acc, mplier   : current upper/lower halves of the partial product
//   mcand         : multiplicand
//   acc_next,
//   mplier_next   : halves after conditional add and a 1-bit right shift of
//                   {carry, acc, mplier}
module mul_step #(
  parameter int N = 64
) (
  input  logic [N-1:0] acc,
  input  logic [N-1:0] mplier,
  input  logic [N-1:0] mcand,
  output logic [N-1:0] acc_next,
  output logic [N-1:0] mplier_next
);

  logic [N:0] sum;

  // The carry out of the add lands in acc's MSB after the shift, so the full
  // 2N-bit product never overflows.
  always_comb begin
    sum         = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(N+1){1'b0}});
    acc_next    = sum[N:1];
    mplier_next = {sum[0], mplier[N-1:1]};
  end

endmodule

// File: rtl/exec_mul_ctrl.sv
// Multi-cycle 64x64 unsigned multiply sequencer (MUL / UMULH) for EX.
// Holds the pipeline via stall_E until the selected product half is taken.
//   clk, reset : clock and asynchronous active-high reset
//   mul        : request/result bundle (exec_mul_ctrl_if.slave)
//   state_dbg  : current FSM state, for observation only
// Optional build macro EXEC_MUL_ZERO_SKIP_EN: a zero operand skips the
// shift-add loop and reaches DONE one cycle after issue.
module exec_mul_ctrl
  import exec_mul_pkg::*;
#(
  parameter int N = MUL_DEFAULT_N
) (
  input  logic              clk,
  input  logic              reset,
  exec_mul_ctrl_if.slave    mul,
  output mul_state_t        state_dbg
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  mul_state_t    state;
  mul_state_t    state_next;
  logic [N-1:0]  acc;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic [CW-1:0] cnt;
  logic          hi_sel_q;
  logic [N-1:0]  acc_step;
  logic [N-1:0]  mplier_step;
  logic          issue;
  logic          zero_op;

  assign issue = mul.start_E & ~mul.flush_E;

`ifdef EXEC_MUL_ZERO_SKIP_EN
  assign zero_op = (mul.opA_E == '0) | (mul.opB_E == '0);
`else
  assign zero_op = 1'b0;
`endif

  mul_step #(.N(N)) u_step (
    .acc         (acc),
    .mplier      (mplier),
    .mcand       (mcand),
    .acc_next    (acc_step),
    .mplier_next (mplier_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and outputs. A flush in RUN/DONE drops stall and valid in the
  // same cycle so the squashed instruction cannot complete a handshake.
  always_comb begin
    state_next       = state;
    mul.stall_E      = 1'b0;
    mul.result_valid = 1'b0;
    mul.result       = '0;
    unique case (state)
      IDLE: begin
        if (issue) begin
          mul.stall_E = 1'b1;
          state_next  = zero_op ? DONE : RUN;
        end
      end
      RUN: begin
        if (mul.flush_E) begin
          state_next = IDLE;
        end else begin
          mul.stall_E = 1'b1;
          if (cnt == CNT_LAST) state_next = DONE;
        end
      end
      DONE: begin
        if (mul.flush_E) begin
          state_next = IDLE;
        end else begin
          mul.result_valid = 1'b1;
          mul.result       = hi_sel_q ? acc : mplier;
          mul.stall_E      = ~mul.result_ready;
          if (mul.result_ready) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mul.busy  = (state != IDLE);
  assign state_dbg = state;

  // Datapath registers; {acc, mplier} becomes the product after N steps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      hi_sel_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            acc      <= '0;
            mcand    <= mul.opA_E;
            mplier   <= zero_op ? '0 : mul.opB_E;
            cnt      <= '0;
            hi_sel_q <= mul.hi_sel_E;
          end
        end
        RUN: begin
          if (!mul.flush_E) begin
            acc    <= acc_step;
            mplier <= mplier_step;
            cnt    <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_mul_ctrl.sv
module tb_exec_mul_ctrl;
  import exec_mul_pkg::*;

  localparam int N = 64;
  localparam int WAIT_MAX = 200;

  logic       clk;
  logic       reset;
  mul_state_t state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_q[$];

  exec_mul_ctrl_if #(.N(N)) bus ();

  exec_mul_ctrl #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .mul       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] ref_mul(input logic [N-1:0] a,
                                           input logic [N-1:0] b,
                                           input logic hi);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    return hi ? p[2*N-1:N] : p[N-1:0];
  endfunction

  function automatic int ref_latency(input logic [N-1:0] a, input logic [N-1:0] b);
    int lat;
    lat = N + 1;
`ifdef EXEC_MUL_ZERO_SKIP_EN
    if (a == '0 || b == '0) lat = 1;
`endif
    return lat;
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    bus.start_E      = 1'b0;
    bus.hi_sel_E     = 1'b0;
    bus.opA_E        = '0;
    bus.opB_E        = '0;
    bus.flush_E      = 1'b0;
    bus.result_ready = 1'b0;
  endtask

  // Issues one multiply at the current (post-negedge) time, waits for the
  // result, holds result_ready low for 'hold' cycles, then takes it.
  task automatic run_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic hi, input int hold, input string tag);
    int cyc;
    int stall_drop;
    int lat;
    logic [N-1:0] exp;
    exp_q.push_back(ref_mul(a, b, hi));
    lat = ref_latency(a, b);
    bus.start_E      = 1'b1;
    bus.opA_E        = a;
    bus.opB_E        = b;
    bus.hi_sel_E     = hi;
    bus.flush_E      = 1'b0;
    bus.result_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.stall_E !== 1'b1 || bus.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s issue_cycle: stall=%b valid=%b, required stall=1 valid=0",
               tag, bus.stall_E, bus.result_valid);
    end
    cyc = 0;
    stall_drop = 0;
    while (cyc < WAIT_MAX) begin
      @(negedge clk);
      cyc++;
      // Operands change after issue; the sequencer must have latched them.
      bus.start_E  = 1'b0;
      bus.opA_E    = {$urandom, $urandom};
      bus.opB_E    = {$urandom, $urandom};
      bus.hi_sel_E = 1'($urandom);
      #1;
      if (bus.result_valid === 1'b1) break;
      if (bus.stall_E !== 1'b1) stall_drop++;
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: result_valid not seen within %0d cycles", tag, WAIT_MAX);
      return;
    end
    n_checks++;
    if (cyc != lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, required %0d", tag, cyc, lat);
    end
    n_checks++;
    if (stall_drop != 0) begin
      n_fail++;
      $display("FAIL %s stall_while_busy: stall low in %0d cycles, required 0", tag, stall_drop);
    end
    n_checks++;
    if (bus.result !== exp || bus.stall_E !== 1'b1) begin
      n_fail++;
      $display("FAIL %s result: got %h stall=%b, required %h stall=1", tag, bus.result, bus.stall_E, exp);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.result_valid, bus.stall_E, bus.result} !== {1'b1, 1'b1, exp}) begin
        n_fail++;
        $display("FAIL %s hold%0d: valid=%b stall=%b result=%h, required 1 1 %h",
                 tag, i, bus.result_valid, bus.stall_E, bus.result, exp);
      end
    end
    bus.result_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.stall_E !== 1'b0 || bus.result_valid !== 1'b1 || bus.result !== exp) begin
      n_fail++;
      $display("FAIL %s handshake: stall=%b valid=%b result=%h, required 0 1 %h",
               tag, bus.stall_E, bus.result_valid, bus.result, exp);
    end
    @(negedge clk);
    bus.result_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 || bus.stall_E !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_handshake: valid=%b busy=%b stall=%b, required 0 0 0",
               tag, bus.result_valid, bus.busy, bus.stall_E);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #7;
    n_checks++;
    if ({bus.busy, bus.result_valid, bus.stall_E} !== 3'b000 || bus.result !== '0
        || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b valid=%b stall=%b result=%h state=%0d, required all 0",
               bus.busy, bus.result_valid, bus.stall_E, bus.result, state_dbg);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b state=%0d, required 0 IDLE", bus.busy, state_dbg);
    end
  endtask

  task automatic test_basic();
    run_mul(64'd3, 64'd5, 1'b0, 0, "mul_3x5");
    run_mul('1, '1, 1'b1, 0, "umulh_ones");
    run_mul('1, '1, 1'b0, 0, "mul_ones");
    run_mul(64'h8000_0000_0000_0000, 64'd2, 1'b1, 0, "umulh_carry");
  endtask

  task automatic test_hold();
    run_mul(64'd1234567, 64'd7654321, 1'b0, 5, "hold5");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (k < 2) b = N'($urandom_range(1, 255));
      run_mul(a, b, 1'($urandom), $urandom_range(0, 3), $sformatf("rand%0d", k));
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++)
      run_mul({$urandom, $urandom}, {$urandom, $urandom}, 1'(k), 0, $sformatf("b2b%0d", k));
  endtask

  task automatic test_flush();
    int seen;
    bool_unused_guard: begin end
    // Flush in RUN
    bus.start_E = 1'b1;
    bus.opA_E   = 64'd9;
    bus.opB_E   = 64'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start_E = 1'b0;
    end
    bus.flush_E = 1'b1;
    #1;
    n_checks++;
    if (bus.stall_E !== 1'b0 || bus.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_run_cycle: stall=%b valid=%b, required 0 0", bus.stall_E, bus.result_valid);
    end
    @(negedge clk);
    bus.flush_E = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL flush_run_idle: busy=%b state=%0d, required 0 IDLE", bus.busy, state_dbg);
    end
    seen = 0;
    for (int i = 0; i < N + 10; i++) begin
      @(negedge clk);
      #1;
      if (bus.result_valid !== 1'b0 || bus.stall_E !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_no_valid: valid/stall seen in %0d cycles, required 0", seen);
    end
    run_mul(64'd7, 64'd6, 1'b0, 0, "after_flush_7x6");

    // Flush in DONE
    bus.start_E = 1'b1;
    bus.opA_E   = 64'd2;
    bus.opB_E   = 64'd3;
    seen = 0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      bus.start_E = 1'b0;
      #1;
      if (bus.result_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (seen != 1) begin
      n_fail++;
      $display("FAIL flush_done_timeout: result_valid not seen within %0d cycles", WAIT_MAX);
    end
    bus.flush_E = 1'b1;
    #1;
    n_checks++;
    if (bus.result_valid !== 1'b0 || bus.stall_E !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done_cycle: valid=%b stall=%b, required 0 0", bus.result_valid, bus.stall_E);
    end
    @(negedge clk);
    bus.flush_E = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done_idle: busy=%b, required 0", bus.busy);
    end

    // Start squashed by a same-cycle flush
    bus.start_E = 1'b1;
    bus.flush_E = 1'b1;
    #1;
    n_checks++;
    if (bus.stall_E !== 1'b0) begin
      n_fail++;
      $display("FAIL start_flush_stall: stall=%b, required 0", bus.stall_E);
    end
    @(negedge clk);
    bus.start_E = 1'b0;
    bus.flush_E = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_flush_idle: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.start_E = 1'b1;
    bus.opA_E   = 64'd11;
    bus.opB_E   = 64'd13;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start_E = 1'b0;
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.result_valid, bus.stall_E} !== 3'b000 || bus.result !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b valid=%b stall=%b result=%h, required all 0",
               bus.busy, bus.result_valid, bus.stall_E, bus.result);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b state=%0d, required 0 IDLE", bus.busy, state_dbg);
    end
    @(negedge clk);
    run_mul(64'd3, 64'd5, 1'b0, 0, "after_reset_3x5");
  endtask

  task automatic test_zero();
    run_mul(64'hDEAD_BEEF, 64'd0, 1'b0, 0, "zero_opB");
    run_mul(64'd0, 64'hCAFE, 1'b1, 1, "zero_opA_hi");
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid_run();
    test_zero();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
